rtc_pclk_sync_multi: RTL

- Parametrised PCLK-domain synchroniser for the RTC.
- Transfers a COUNT_W-bit counter value from the RTC clock domain into PCLK using a toggle handshake. The source asserts a toggle, and the value is held stable while the toggle propagates.
- Synchronises NUM_INT asynchronous interrupt sources. Each channel has selectable level or latched-rising-edge mode, write-1-to-clear pending bits, masking and a combined interrupt output.
- Sits between the RTC counter/match core and the APB register block.

---
 rtl/rtc_sync_pkg.sv | 22 ++
 rtl/rtc_pclk_sync_multi_if.sv | 37 +++
 rtl/rtc_sync_bit.sv | 25 ++
 rtl/rtc_pclk_sync_multi.sv | 111 +++++++++++
 4 files changed

// File: rtl/rtc_sync_pkg.sv
// Shared constants and parameter range check for the RTC PCLK-domain synchroniser.
package rtc_sync_pkg;

   localparam int unsigned DEF_COUNT_W     = 32;
   localparam int unsigned DEF_NUM_INT     = 2;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   localparam int unsigned MIN_SYNC_STAGES = 2;
   localparam int unsigned MAX_SYNC_STAGES = 4;
   localparam int unsigned MAX_COUNT_W     = 64;
   localparam int unsigned MAX_NUM_INT     = 16;

   // True when the parameter set is one the synchroniser supports.
   function automatic bit paramsOk(input int unsigned countW,
                                   input int unsigned numInt,
                                   input int unsigned syncStages);
      return (countW >= 1) && (countW <= MAX_COUNT_W) &&
             (numInt >= 1) && (numInt <= MAX_NUM_INT) &&
             (syncStages >= MIN_SYNC_STAGES) && (syncStages <= MAX_SYNC_STAGES);
   endfunction

endpackage

// File: rtl/rtc_pclk_sync_multi_if.sv
// Bus between the RTC counter/match core (master) and the PCLK synchroniser (slave).
interface rtc_pclk_sync_multi_if
   import rtc_sync_pkg::*;
#(
   parameter int unsigned COUNT_W = DEF_COUNT_W,
   parameter int unsigned NUM_INT = DEF_NUM_INT
);

   logic [COUNT_W-1:0] CountIn;
   logic               CountTgl;
   logic [NUM_INT-1:0] IntRaw;
   logic [NUM_INT-1:0] IntMask;
   logic [NUM_INT-1:0] EdgeMode;
   logic [NUM_INT-1:0] IntClr;

   logic [COUNT_W-1:0] CountSync;
   logic               CountUpd;
   logic               CountWrap;
   logic [NUM_INT-1:0] RawIntSync;
   logic [NUM_INT-1:0] RawIntEdge;
   logic [NUM_INT-1:0] IntPend;
   logic [NUM_INT-1:0] MaskIntStatus;
   logic               IntOut;

   modport master (
      output CountIn, CountTgl, IntRaw, IntMask, EdgeMode, IntClr,
      input  CountSync, CountUpd, CountWrap, RawIntSync, RawIntEdge,
             IntPend, MaskIntStatus, IntOut
   );

   modport slave (
      input  CountIn, CountTgl, IntRaw, IntMask, EdgeMode, IntClr,
      output CountSync, CountUpd, CountWrap, RawIntSync, RawIntEdge,
             IntPend, MaskIntStatus, IntOut
   );

endinterface

// File: rtl/rtc_sync_bit.sv
// Single-bit multi-flop synchroniser into PCLK; all stages reset to 0.
module rtc_sync_bit
   import rtc_sync_pkg::*;
#(
   parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic Async,
   output logic Sync
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], Async};
      end
   end

   assign Sync = chain[STAGES-1];

endmodule

// File: rtl/rtc_pclk_sync_multi.sv
// Brings the RTC counter (toggle handshake) and NUM_INT interrupt sources into PCLK,
// with per-channel level/latched-edge pending, write-1-to-clear and masking.
module rtc_pclk_sync_multi
   import rtc_sync_pkg::*;
#(
   parameter int unsigned COUNT_W     = DEF_COUNT_W,
   parameter int unsigned NUM_INT     = DEF_NUM_INT,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input logic                  PCLK,
   input logic                  PRESETn,
   rtc_pclk_sync_multi_if.slave syncIf
);

   if (!paramsOk(COUNT_W, NUM_INT, SYNC_STAGES)) begin : gParamCheck
      $error("rtc_pclk_sync_multi: COUNT_W/NUM_INT/SYNC_STAGES out of range");
   end

   logic               tglS;
   logic               tglH;
   logic               cntEv;
   logic [COUNT_W-1:0] countSync;
   logic               countUpd;
   logic               countWrap;

   logic [NUM_INT-1:0] rawSync;
   logic [NUM_INT-1:0] rawHist;
   logic [NUM_INT-1:0] rawEdge;
   logic [NUM_INT-1:0] pendReg;
   logic [NUM_INT-1:0] pendNext;
   logic [NUM_INT-1:0] intPend;
   logic [NUM_INT-1:0] maskStatus;

   rtc_sync_bit #(.STAGES(SYNC_STAGES)) uTglSync (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .Async   (syncIf.CountTgl),
      .Sync    (tglS)
   );

   // A toggle edge seen in PCLK marks CountIn as stable and ready to capture.
   assign cntEv = tglS ^ tglH;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tglH      <= 1'b0;
         countSync <= '0;
         countUpd  <= 1'b0;
         countWrap <= 1'b0;
      end else begin
         tglH      <= tglS;
         countUpd  <= cntEv;
         countWrap <= cntEv && (syncIf.CountIn < countSync);
         if (cntEv) begin
            countSync <= syncIf.CountIn;
         end
      end
   end

   for (genvar i = 0; i < NUM_INT; i++) begin : gIntSync
      rtc_sync_bit #(.STAGES(SYNC_STAGES)) uIntSync (
         .PCLK    (PCLK),
         .PRESETn (PRESETn),
         .Async   (syncIf.IntRaw[i]),
         .Sync    (rawSync[i])
      );
   end

   assign rawEdge = rawSync & ~rawHist;

   // Edge-mode latch: a new edge beats a coincident clear; level mode keeps it empty.
   always_comb begin
      pendNext = '0;
      for (int i = 0; i < NUM_INT; i++) begin
         if (syncIf.EdgeMode[i]) begin
            pendNext[i] = rawEdge[i] | (pendReg[i] & ~syncIf.IntClr[i]);
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rawHist <= '0;
         pendReg <= '0;
      end else begin
         rawHist <= rawSync;
         pendReg <= pendNext;
      end
   end

   always_comb begin
      intPend = rawSync;
      for (int i = 0; i < NUM_INT; i++) begin
         if (syncIf.EdgeMode[i]) begin
            intPend[i] = pendReg[i];
         end
      end
   end

   assign maskStatus = intPend & syncIf.IntMask;

   assign syncIf.CountSync     = countSync;
   assign syncIf.CountUpd      = countUpd;
   assign syncIf.CountWrap     = countWrap;
   assign syncIf.RawIntSync    = rawSync;
   assign syncIf.RawIntEdge    = rawEdge;
   assign syncIf.IntPend       = intPend;
   assign syncIf.MaskIntStatus = maskStatus;
   assign syncIf.IntOut        = |maskStatus;

endmodule
